// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AddRoundKey block:
//   - rk_state_t    : key-store FSM states (EMPTY / LOADING / READY)
//   - AES*_ROUNDS   : legal round counts for AES-128/192/256
//   - key_index()   : maps (round_idx, decrypt) to a round-key slot
// ----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } rk_state_t;

    localparam int unsigned AES128_ROUNDS = 10;
    localparam int unsigned AES192_ROUNDS = 12;
    localparam int unsigned AES256_ROUNDS = 14;

    // Decryption walks the schedule backwards. The result is only meaningful
    // for round_idx <= num_rounds; callers gate out-of-range indices.
    function automatic int unsigned key_index(input int unsigned round_idx,
                                              input logic        decrypt,
                                              input int unsigned num_rounds);
        if (decrypt)
            return num_rounds - round_idx;
        else
            return round_idx;
    endfunction

endpackage

// File: rtl/rk_store.sv
// ----------------------------------------------------------------------------
// rk_store
// Round-key register file with sequential load pointer and read mux.
//   clk, rst     : clock, synchronous active-high reset (pointer only)
//   restart      : returns the load pointer to slot 0
//   wr_en        : write wr_data at the pointer and advance it
//   wr_data      : round key being loaded
//   last_key     : pointer sits on the final slot (NUM_ROUNDS)
//   round_idx    : requested round
//   decrypt      : reverse key order
//   rd_hit       : round_idx is within 0..NUM_ROUNDS
//   rd_data      : selected round key ('0 when rd_hit is low)
// Key contents are deliberately not reset.
// ----------------------------------------------------------------------------
module rk_store
    import aes_pkg::*;
#(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned IDX_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              last_key,
    input  logic [IDX_W-1:0]  round_idx,
    input  logic              decrypt,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned      NUM_KEYS = NUM_ROUNDS + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    logic [DATA_W-1:0] keys [NUM_KEYS];
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  sel;

    assign last_key = (ptr == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst || restart)
            ptr <= '0;
        else if (wr_en)
            ptr <= last_key ? '0 : ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            keys[ptr] <= wr_data;
    end

    assign sel    = IDX_W'(key_index(32'(round_idx), decrypt, NUM_ROUNDS));
    assign rd_hit = (round_idx <= LAST_IDX);

    always_comb begin
        rd_data = '0;
        if (rd_hit)
            rd_data = keys[sel];
    end

endmodule

// File: rtl/round_key_adder.sv
// ----------------------------------------------------------------------------
// round_key_adder
// AES AddRoundKey stage: XORs a state word with a stored round key, with a
// one-deep registered output and valid/ready handshakes.
//   clk, rst              : clock, synchronous active-high reset
//   key_start             : restart the key load (clears key_loaded)
//   key_valid/key_ready   : round-key load handshake, key_in in index order
//   key_loaded            : all NUM_ROUNDS+1 keys are stored
//   in_valid/in_ready     : data input handshake (data_in, round_idx,
//                           decrypt, enable)
//   out_valid/out_ready   : data output handshake (data_out, idx_err)
//   idx_err               : round_idx was out of range with enable=1
// ----------------------------------------------------------------------------
module round_key_adder
    import aes_pkg::*;
#(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned IDX_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_start,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [DATA_W-1:0] key_in,
    output logic              key_loaded,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [IDX_W-1:0]  round_idx,
    input  logic              decrypt,
    input  logic              enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              idx_err
);

    rk_state_t         state, state_d;
    logic              key_wr;
    logic              last_key;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_key;
    logic              accept;
    logic [DATA_W-1:0] result;
    logic              result_err;

    // key_start wins over a same-cycle key beat; that beat is discarded.
    assign key_wr = key_valid & key_ready & ~key_start;

    rk_store #(
        .DATA_W     (DATA_W),
        .NUM_ROUNDS (NUM_ROUNDS),
        .IDX_W      (IDX_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .restart   (key_start),
        .wr_en     (key_wr),
        .wr_data   (key_in),
        .last_key  (last_key),
        .round_idx (round_idx),
        .decrypt   (decrypt),
        .rd_hit    (rd_hit),
        .rd_data   (rd_key)
    );

    // ------------------------------------------------------------------
    // Key-load FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_d;
    end

    always_comb begin
        state_d    = state;
        key_ready  = 1'b0;
        key_loaded = 1'b0;
        case (state)
            EMPTY: begin
                if (key_start)
                    state_d = LOADING;
            end
            LOADING: begin
                key_ready = 1'b1;
                if (key_start)
                    state_d = LOADING;
                else if (key_wr && last_key)
                    state_d = READY;
            end
            READY: begin
                key_loaded = 1'b1;
                if (key_start)
                    state_d = LOADING;
            end
            default: state_d = EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output register
    // ------------------------------------------------------------------
    assign in_ready = key_loaded & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        result     = data_in;
        result_err = 1'b0;
        if (enable) begin
            if (rd_hit)
                result = data_in ^ rd_key;
            else
                result_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            idx_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            data_out  <= result;
            idx_err   <= result_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_round_key_adder.sv
module tb_round_key_adder;

    localparam int DW = 128;
    localparam int NR = 10;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic          key_start;
    logic          key_valid;
    logic          key_ready;
    logic [DW-1:0] key_in;
    logic          key_loaded;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_in;
    logic [IW-1:0] round_idx;
    logic          decrypt;
    logic          enable;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic          idx_err;

    round_key_adder #(
        .DATA_W     (DW),
        .NUM_ROUNDS (NR),
        .IDX_W      (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_start  (key_start),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .key_loaded (key_loaded),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .round_idx  (round_idx),
        .decrypt    (decrypt),
        .enable     (enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .idx_err    (idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mkeys [NR+1];

    typedef struct {
        logic [DW-1:0] din;
        logic [IW-1:0] idx;
        logic          dec;
        logic          en;
        logic [DW-1:0] exp_out;
        logic          exp_err;
    } vec_t;

    vec_t vecs [11];

    typedef struct {
        logic [DW-1:0] out;
        logic          err;
    } exp_t;

    exp_t q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // AddRoundKey rules applied to the bench's own copy of the keys.
    function automatic exp_t model(input logic [DW-1:0] din, input int idx,
                                   input logic dec, input logic en);
        exp_t r;
        r.out = din;
        r.err = 1'b0;
        if (en) begin
            if (idx > NR)
                r.err = 1'b1;
            else
                r.out = din ^ mkeys[dec ? NR - idx : idx];
        end
        return r;
    endfunction

    task automatic load_keys(input logic [7:0] base, input int n, input bit do_start);
        logic [7:0] b;
        if (do_start) begin
            key_start = 1'b1;
            step();
            key_start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            b         = base + 8'(i);
            key_in    = {16{b}};
            key_valid = 1'b1;
            #1;
            chk("key_ready_loading", key_ready, 1);
            chk("key_loaded_early", key_loaded, 0);
            step();
            mkeys[i] = {16{b}};
        end
        key_valid = 1'b0;
        if (n == NR + 1) begin
            chk("key_loaded_done", key_loaded, 1);
            chk("key_ready_done", key_ready, 0);
        end
    endtask

    task automatic xfer(input logic [DW-1:0] din, input logic [IW-1:0] idx,
                        input logic dec, input logic en,
                        output logic [DW-1:0] dout, output logic err);
        data_in   = din;
        round_idx = idx;
        decrypt   = dec;
        enable    = en;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("xfer_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("xfer_out_valid", out_valid, 1);
        dout = data_out;
        err  = idx_err;
        step();
    endtask

    localparam logic [DW-1:0] X = 128'h0123456789abcdef_fedcba9876543210;

    initial begin
        logic [DW-1:0] dout;
        logic          err;
        logic [DW-1:0] w [5];
        exp_t          e, e_prev;
        bit            exp_rdy;

        vecs[0]  = '{128'h0, 4'd3,  1'b0, 1'b1, {16{8'h03}},      1'b0};
        vecs[1]  = '{X,      4'd3,  1'b1, 1'b1, X ^ {16{8'h07}},  1'b0};
        vecs[2]  = '{X,      4'd11, 1'b0, 1'b1, X,                1'b1};
        vecs[3]  = '{X,      4'd15, 1'b0, 1'b0, X,                1'b0};
        vecs[4]  = '{X,      4'd0,  1'b0, 1'b1, X,                1'b0};
        vecs[5]  = '{X,      4'd0,  1'b1, 1'b1, X ^ {16{8'h0A}},  1'b0};
        vecs[6]  = '{X,      4'd10, 1'b1, 1'b1, X,                1'b0};
        vecs[7]  = '{X,      4'd10, 1'b0, 1'b1, X ^ {16{8'h0A}},  1'b0};
        vecs[8]  = '{X,      4'd15, 1'b1, 1'b1, X,                1'b1};
        vecs[9]  = '{X,      4'd11, 1'b0, 1'b0, X,                1'b0};
        vecs[10] = '{X,      4'd7,  1'b1, 1'b1, X ^ {16{8'h03}},  1'b0};

        rst = 1'b1; key_start = 1'b0; key_valid = 1'b0; key_in = '0;
        in_valid = 1'b0; data_in = '0; round_idx = '0; decrypt = 1'b0;
        enable = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_idx_err", idx_err, 0);
        chk("rst_key_loaded", key_loaded, 0);
        chk("rst_key_ready", key_ready, 0);
        chk("rst_in_ready", in_ready, 0);

        // Directed vectors with keys {16{i}}
        load_keys(8'h00, NR + 1, 1'b1);
        for (int i = 0; i < 11; i++) begin
            xfer(vecs[i].din, vecs[i].idx, vecs[i].dec, vecs[i].en, dout, err);
            chk($sformatf("vec%0d_data", i), dout, vecs[i].exp_out);
            chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
        end

        // Restart mid-load; the key beat coinciding with key_start is dropped
        load_keys(8'h50, 5, 1'b1);
        chk("partial_key_loaded", key_loaded, 0);
        key_start = 1'b1;
        key_valid = 1'b1;
        key_in    = {16{8'h77}};
        step();
        key_start = 1'b0;
        key_valid = 1'b0;
        load_keys(8'hA0, NR + 1, 1'b0);
        xfer(X, 4'd0, 1'b0, 1'b1, dout, err);
        chk("reload_round0", dout, X ^ {16{8'hA0}});
        xfer(X, 4'd2, 1'b0, 1'b1, dout, err);
        chk("reload_round2", dout, X ^ {16{8'hA2}});
        chk("reload_round2_err", err, 0);

        // Backpressure: hold out_ready low for 3 cycles, then stream
        for (int i = 0; i < 5; i++)
            w[i] = {$urandom, $urandom, $urandom, $urandom};
        round_idx = 4'd1; decrypt = 1'b0; enable = 1'b1;
        data_in = w[0]; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk("bp_in_ready_first", in_ready, 1);
        step();
        data_in = w[1];
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", data_out, model(w[0], 1, 1'b0, 1'b1).out);
            chk("bp_hold_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            data_in = w[k];
            #1;
            chk("bp_stream_in_ready", in_ready, 1);
            chk("bp_stream_valid", out_valid, 1);
            chk("bp_stream_data", data_out, model(w[k-1], 1, 1'b0, 1'b1).out);
            step();
        end
        in_valid = 1'b0;
        chk("bp_last_valid", out_valid, 1);
        chk("bp_last_data", data_out, model(w[4], 1, 1'b0, 1'b1).out);
        step();
        chk("bp_drained", out_valid, 0);

        // key_start while an output is pending
        e = model(X, 5, 1'b1, 1'b1);
        data_in = X; round_idx = 4'd5; decrypt = 1'b1; enable = 1'b1;
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid  = 1'b0;
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        in_valid  = 1'b1;
        #1;
        chk("ks_pending_valid", out_valid, 1);
        chk("ks_pending_data", data_out, e.out);
        chk("ks_in_ready", in_ready, 0);
        chk("ks_key_ready", key_ready, 1);
        out_ready = 1'b1;
        step();
        chk("ks_delivered", out_valid, 0);
        chk("ks_in_ready_stall", in_ready, 0);
        in_valid = 1'b0;
        load_keys(8'h30, NR + 1, 1'b0);

        // Reset mid-load, with key_start and a key beat in the same cycle
        load_keys(8'h10, 3, 1'b1);
        rst = 1'b1; key_start = 1'b1; key_valid = 1'b1;
        step();
        rst = 1'b0; key_start = 1'b0; key_valid = 1'b0;
        chk("rstload_key_ready", key_ready, 0);
        chk("rstload_key_loaded", key_loaded, 0);
        chk("rstload_out_valid", out_valid, 0);
        step();
        chk("rstload_stays_empty", key_ready, 0);

        // Reset while an output is pending
        load_keys(8'h60, NR + 1, 1'b1);
        data_in = X; round_idx = 4'd4; decrypt = 1'b0; enable = 1'b1;
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        chk("rstout_pending", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rstout_out_valid", out_valid, 0);
        chk("rstout_data_out", data_out, 0);
        chk("rstout_idx_err", idx_err, 0);
        chk("rstout_key_loaded", key_loaded, 0);
        chk("rstout_key_ready", key_ready, 0);

        // Randomized traffic against the reference model
        load_keys(8'($urandom_range(0, 255)), NR + 1, 1'b1);
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            data_in   = {$urandom, $urandom, $urandom, $urandom};
            round_idx = IW'($urandom_range(0, 15));
            decrypt   = $urandom_range(0, 1);
            enable    = ($urandom_range(0, 9) < 8);
            #1;
            exp_rdy = (q.size() == 0) || out_ready;
            chk("rnd_in_ready", in_ready, exp_rdy);
            chk("rnd_out_valid", out_valid, q.size() != 0);
            if (q.size() != 0 && out_ready) begin
                e_prev = q.pop_front();
                chk("rnd_data_out", data_out, e_prev.out);
                chk("rnd_idx_err", idx_err, e_prev.err);
            end
            if (in_valid && exp_rdy)
                q.push_back(model(data_in, int'(round_idx), decrypt, enable));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        if (q.size() != 0) begin
            e_prev = q.pop_front();
            chk("rnd_drain_valid", out_valid, 1);
            chk("rnd_drain_data", data_out, e_prev.out);
            chk("rnd_drain_err", idx_err, e_prev.err);
        end
        step();
        chk("rnd_final_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_key_adder.md
ROUND_KEY_ADDER -- requirements
Module: round_key_adder

Interface
REQ-001 Parameter DATA_W, default 128: state and round-key width in bits.
REQ-002 Parameter NUM_ROUNDS, default 10: legal values 10, 12 or 14; NUM_KEYS = NUM_ROUNDS+1 round keys are stored.
REQ-003 Parameter IDX_W, default 4: width of the round index; must satisfy 2**IDX_W > NUM_ROUNDS.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port key_start, input, 1: pulse; restarts the key load at index 0 and clears key_loaded.
REQ-007 Port key_valid / key_ready, input / output, 1 each: round-key load handshake.
REQ-008 Port key_in, input, DATA_W: round key, delivered in order from index 0 to NUM_ROUNDS.
REQ-009 Port key_loaded, output, 1: high once all NUM_KEYS keys are stored.
REQ-010 Port in_valid / in_ready, input / output, 1 each: data-input handshake.
REQ-011 Port data_in, input, DATA_W: state word to be keyed.
REQ-012 Port round_idx, input, IDX_W: round number accompanying data_in.
REQ-013 Port decrypt, input, 1: 1 selects key index NUM_ROUNDS-round_idx; 0 selects key index round_idx.
REQ-014 Port enable, input, 1: 0 passes data_in through unmodified.
REQ-015 Port out_valid / out_ready, output / input, 1 each: data-output handshake.
REQ-016 Port data_out, output, DATA_W: registered result.
REQ-017 Port idx_err, output, 1: registered with data_out; flags an out-of-range round_idx.

Function
REQ-018 Key store: NUM_KEYS x DATA_W registers plus a load pointer that counts 0..NUM_ROUNDS.
REQ-019 FSM states: EMPTY, LOADING, READY. EMPTY->LOADING on key_start; LOADING->READY when key NUM_ROUNDS is accepted; READY->LOADING on key_start.
REQ-020 key_ready = 1 only in LOADING. A key is written at pointer position when key_valid&key_ready, and the pointer increments.
REQ-021 key_start in any state, including mid-load, resets the pointer to 0 on the next edge. key_start has priority over a same-cycle key write; that key is dropped.
REQ-022 key_loaded = 1 only in READY.
REQ-023 in_ready = key_loaded & (~out_valid | out_ready). An input is accepted when in_valid&in_ready.
REQ-024 Latency: data_out appears one cycle after acceptance. Back-to-back throughput: one word per cycle while out_ready=1.
REQ-025 On acceptance with enable=1 and round_idx <= NUM_ROUNDS: data_out = data_in XOR key[sel]; sel is set by decrypt per REQ-013; idx_err = 0.
REQ-026 round_idx > NUM_ROUNDS with enable=1: data_out = data_in unmodified; idx_err = 1.
REQ-027 enable=0: data_out = data_in; idx_err = 0, regardless of round_idx.
REQ-028 out_valid is set on acceptance. It is cleared when out_ready=1 and there is no new acceptance. data_out and idx_err hold while out_valid=1 and out_ready=0.
REQ-029 key_start while out_valid=1: the pending output is kept and delivered; new inputs stall until READY.

Reset
REQ-030 rst=1 at a clock edge: FSM->EMPTY, pointer=0, out_valid=0, data_out=0, idx_err=0, key_loaded=0, key_ready=0.
REQ-031 Key store contents are not reset; they are undefined until reloaded.
REQ-032 rst has priority over key_start and over both handshakes in the same cycle.

Structure
REQ-033 Shared package aes_pkg holds the FSM state enum, the legal NUM_ROUNDS constants (10/12/14) and the key-index function (round_idx, decrypt -> sel).
REQ-034 One sub-module, rk_store: key registers, load pointer and read mux; the top holds the FSM and the output register.

Verification
REQ-035 Load keys k[i] = {16{8'(i)}}, i=0..10; then data_in=0, round_idx=3, decrypt=0, enable=1 -> data_out=128'h0303...03 one cycle later, idx_err=0.
REQ-036 Same keys; round_idx=3, decrypt=1 -> data_out = data_in XOR {16{8'h07}}.
REQ-037 round_idx=11 (NUM_ROUNDS=10), enable=1 -> data_out = data_in, idx_err=1. With enable=0 and round_idx=15 -> data_out = data_in, idx_err=0.
REQ-038 key_start after 5 keys are loaded, then 11 keys reloaded with 8'hA0+i -> key_loaded rises only after the 11th key; round 2 then uses {16{8'hA2}}.
REQ-039 Hold out_ready=0 for 3 cycles with in_valid=1 -> data_out stable, in_ready=0; on release, one word completes per cycle with no loss or duplication.
REQ-040 Assert rst mid-load and again with out_valid=1 -> next cycle out_valid=0, key_loaded=0, key_ready=0, FSM in EMPTY.
